// File: rtl/pl_irq_pkg.sv
// pl_irq_pkg: shared FSM states, next-PC select codes and trap constants for the next-PC/IRQ controller
package pl_irq_pkg;
  typedef enum logic [1:0] {RUN, DRAIN, ENTER} state_t;
  localparam logic [1:0] PC_SEQ  = 2'b00;
  localparam logic [1:0] PC_BR   = 2'b01;
  localparam logic [1:0] PC_JAL  = 2'b10;
  localparam logic [1:0] PC_JALR = 2'b11;
  localparam logic [31:0] MTVEC_DEF     = 32'h0000_0008;
  localparam logic [31:0] CAUSE_EXT_DEF = 32'h8000_000B;
endpackage

// File: rtl/pl_npc_sel.sv
// pl_npc_sel: 4:1 next-PC target mux with pc+4 adder
// Ports: pc (current PC), pcsrc (00 pc+4, 01 branch, 10 jal, 11 jalr),
//        bpc/jpc/rpc (targets), tgt (selected next PC)
module pl_npc_sel
  import pl_irq_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [1:0]  pcsrc,
  input  logic [31:0] bpc,
  input  logic [31:0] jpc,
  input  logic [31:0] rpc,
  output logic [31:0] tgt
);
  always_comb
    tgt = pcsrc == PC_BR  ? bpc :
          pcsrc == PC_JAL ? jpc :
          pcsrc == PC_JALR ? rpc : pc + 32'd4;
endmodule

// File: rtl/pl_npc_irq_ctrl.sv
// pl_npc_irq_ctrl: next-PC controller with external-interrupt entry and mret return sequencing
// Ports: clk/rst (sync active-high); pc, pcsrc, bpc, jpc, rpc (normal-flow select);
//        stall, intr, mret, fpu_busy (control); npc, wpc, flush, intr_ack (comb to PC reg);
//        mepc, mcause, in_irq (registered CSR state)
module pl_npc_irq_ctrl
  import pl_irq_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] MTVEC     = MTVEC_DEF,
  parameter logic [31:0] CAUSE_EXT = CAUSE_EXT_DEF,
  parameter int          DRAIN_CYC = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  input  logic [1:0]  pcsrc,
  input  logic [31:0] bpc,
  input  logic [31:0] jpc,
  input  logic [31:0] rpc,
  input  logic        stall,
  input  logic        intr,
  input  logic        mret,
  input  logic        fpu_busy,
  output logic [31:0] npc,
  output logic        wpc,
  output logic        flush,
  output logic        intr_ack,
  output logic [31:0] mepc,
  output logic [31:0] mcause,
  output logic        in_irq
);
  localparam int CW = DRAIN_CYC > 0 ? $clog2(DRAIN_CYC + 1) : 1;
  localparam logic [CW-1:0] DMAX = CW'(DRAIN_CYC);
  state_t state, state_nxt;
  logic [CW-1:0] cnt, cnt_inc;
  logic [31:0] tgt;
  logic mret_go, accept, drain_done;
  pl_npc_sel u_sel (
    .pc    (pc),
    .pcsrc (pcsrc),
    .bpc   (bpc),
    .jpc   (jpc),
    .rpc   (rpc),
    .tgt   (tgt)
  );
  // mret wins over acceptance; acceptance only on a sequential, unstalled slot
  always_comb begin
    mret_go    = state == RUN && mret && !stall;
    accept     = state == RUN && intr && !in_irq && !stall && pcsrc == PC_SEQ && !mret;
    cnt_inc    = cnt >= DMAX ? cnt : cnt + 1'b1;
    // judged on the incremented count so exactly DRAIN_CYC drain cycles precede ENTER
    drain_done = cnt_inc >= DMAX && !fpu_busy;
  end
  always_ff @(posedge clk)
    state <= rst ? RUN : state_nxt;
  always_comb
    state_nxt = state == RUN   ? (accept ? DRAIN : RUN) :
                state == DRAIN ? (drain_done ? ENTER : DRAIN) : RUN;
  always_comb begin
    npc      = rst ? RESET_PC : state == ENTER ? MTVEC : mret_go ? mepc : tgt;
    wpc      = rst || state == ENTER || mret_go || (state == RUN && !accept && !stall);
    flush    = rst || state == ENTER || mret_go || accept;
    intr_ack = !rst && state == ENTER;
  end
  always_ff @(posedge clk)
    if (rst) begin
      mepc   <= '0;
      mcause <= '0;
      in_irq <= 1'b0;
      cnt    <= '0;
    end else begin
      if (accept) mepc <= pc;
      cnt <= accept ? '0 : state == DRAIN ? cnt_inc : cnt;
      if (state == ENTER) mcause <= CAUSE_EXT;
      in_irq <= state == ENTER ? 1'b1 : mret_go ? 1'b0 : in_irq;
    end
endmodule

// File: tb/tb_pl_npc_irq_ctrl.sv
// tb_pl_npc_irq_ctrl: directed self-checking bench for pl_npc_irq_ctrl
module tb_pl_npc_irq_ctrl;
  logic clk = 1'b0;
  logic rst, stall, intr, mret, fpu_busy;
  logic [1:0] pcsrc;
  logic [31:0] pc, bpc, jpc, rpc;
  logic [31:0] npc, mepc, mcause;
  logic wpc, flush, intr_ack, in_irq;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  pl_npc_irq_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .pc       (pc),
    .pcsrc    (pcsrc),
    .bpc      (bpc),
    .jpc      (jpc),
    .rpc      (rpc),
    .stall    (stall),
    .intr     (intr),
    .mret     (mret),
    .fpu_busy (fpu_busy),
    .npc      (npc),
    .wpc      (wpc),
    .flush    (flush),
    .intr_ack (intr_ack),
    .mepc     (mepc),
    .mcause   (mcause),
    .in_irq   (in_irq)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic cyc;
    @(posedge clk);
    #1;
  endtask
  task automatic drain_chk(input string tag);
    chk({tag, "_wpc"}, wpc, 0);
    chk({tag, "_flush"}, flush, 0);
    chk({tag, "_ack"}, intr_ack, 0);
  endtask
  initial begin
    rst = 1; stall = 0; intr = 0; mret = 0; fpu_busy = 0;
    pcsrc = 2'b00; pc = 32'h100; bpc = 0; jpc = 0; rpc = 0;
    cyc; cyc;
    chk("rst_npc", npc, 32'h0);
    chk("rst_wpc", wpc, 1);
    chk("rst_flush", flush, 1);
    chk("rst_ack", intr_ack, 0);
    chk("rst_mepc", mepc, 0);
    chk("rst_mcause", mcause, 0);
    chk("rst_in_irq", in_irq, 0);
    rst = 0; #1;
    chk("seq_npc", npc, 32'h104);
    chk("seq_wpc", wpc, 1);
    chk("seq_flush", flush, 0);
    pcsrc = 2'b01; bpc = 32'h200; #1;
    chk("br_npc", npc, 32'h200);
    pcsrc = 2'b10; jpc = 32'h2A0; #1;
    chk("jal_npc", npc, 32'h2A0);
    pcsrc = 2'b11; rpc = 32'h3FC; #1;
    chk("jalr_npc", npc, 32'h3FC);
    stall = 1; #1;
    chk("stall_wpc", wpc, 0);
    pcsrc = 2'b00; pc = 32'hFFFF_FFFC; stall = 0; #1;
    chk("wrap_npc", npc, 32'h0);
    // interrupt refused while stalled or on a non-sequential slot
    intr = 1; stall = 1; pc = 32'h140; #1;
    chk("nacc_stall_flush", flush, 0);
    stall = 0; pcsrc = 2'b01; #1;
    chk("nacc_br_flush", flush, 0);
    chk("nacc_br_wpc", wpc, 1);
    cyc;
    chk("nacc_in_irq", in_irq, 0);
    chk("nacc_mepc", mepc, 0);
    // accepted interrupt, FPU idle
    pcsrc = 2'b00; #1;
    chk("acc_flush", flush, 1);
    chk("acc_wpc", wpc, 0);
    chk("acc_ack", intr_ack, 0);
    cyc;
    intr = 0; pc = 32'h144; #1;
    drain_chk("d1");
    cyc; drain_chk("d2");
    cyc; drain_chk("d3");
    cyc;
    chk("ent_npc", npc, 32'h8);
    chk("ent_wpc", wpc, 1);
    chk("ent_flush", flush, 1);
    chk("ent_ack", intr_ack, 1);
    cyc;
    chk("post_ack", intr_ack, 0);
    chk("post_mepc", mepc, 32'h140);
    chk("post_mcause", mcause, 32'h8000_000B);
    chk("post_in_irq", in_irq, 1);
    // masked while in handler
    intr = 1; pc = 32'h8; #1;
    chk("mask_flush", flush, 0);
    chk("mask_npc", npc, 32'hC);
    chk("mask_wpc", wpc, 1);
    // mret beats acceptance, then tail-chain
    mret = 1; #1;
    chk("mret_npc", npc, 32'h140);
    chk("mret_wpc", wpc, 1);
    chk("mret_flush", flush, 1);
    cyc;
    mret = 0; pc = 32'h300; #1;
    chk("mret_in_irq", in_irq, 0);
    chk("mret_mepc_keep", mepc, 32'h140);
    chk("tail_flush", flush, 1);
    chk("tail_wpc", wpc, 0);
    cyc;
    intr = 0; fpu_busy = 1; #1;
    chk("tail_mepc", mepc, 32'h300);
    for (int i = 0; i < 10; i++) begin
      drain_chk("fpu_busy");
      cyc;
    end
    fpu_busy = 0; #1;
    drain_chk("fpu_free");
    cyc;
    chk("fpu_ent_ack", intr_ack, 1);
    chk("fpu_ent_npc", npc, 32'h8);
    cyc;
    chk("fpu_post_ack", intr_ack, 0);
    chk("fpu_in_irq", in_irq, 1);
    mret = 1; #1;
    chk("mret2_npc", npc, 32'h300);
    cyc;
    mret = 0; #1;
    chk("mret2_in_irq", in_irq, 0);
    // reset in the middle of a drain
    pc = 32'h500; intr = 1; #1;
    chk("acc3_flush", flush, 1);
    cyc;
    intr = 0; #1;
    drain_chk("d_rst");
    rst = 1; #1;
    chk("mrst_npc", npc, 32'h0);
    chk("mrst_ack", intr_ack, 0);
    cyc;
    rst = 0; pc = 32'h40; #1;
    chk("mrst_in_irq", in_irq, 0);
    chk("mrst_mepc", mepc, 0);
    for (int i = 0; i < 5; i++) begin
      chk("mrst_run_ack", intr_ack, 0);
      chk("mrst_run_wpc", wpc, 1);
      chk("mrst_run_npc", npc, 32'h44);
      cyc;
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
